// File: rtl/mux8_sel_sequencer.sv
// mux8_sel_sequencer
//
// Parallel-to-serial front end for an 8:1 data-select mux. A byte is
// accepted over a valid/ready handshake and held on the mux data inputs.
// The 3-bit select then walks all eight positions, holding each one for
// HOLD_CYCLES clocks, so the mux output carries one serial bit per step.
//
// Parameters
//   HOLD_CYCLES : clocks each select value is held (1..256)
//   MSB_FIRST   : 0 = select order 0..7, 1 = select order 7..0
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream word available
//   in_ready   out  block can accept a word (decoded from state only)
//   in_data    in   word to serialise
//   mux_i      out  captured word, drives the mux data inputs
//   mux_s      out  select, drives the mux select inputs
//   bit_valid  out  mux output is a valid serial bit this cycle
//   bit_last   out  current step is the eighth and final step
//   done       out  one-cycle pulse after the frame ends

module mux8_sel_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] mux_i,
    output logic [2:0] mux_s,
    output logic       bit_valid,
    output logic       bit_last,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // HOLD_CYCLES = 256 wraps to a load value of 255 in the 8-bit counter.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_step;
    logic [2:0] w_step_nxt;
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;
    logic       w_capture;

    logic [7:0] r_mux_i;
    logic [2:0] r_mux_s;
    logic       r_bit_valid;
    logic       r_bit_last;
    logic       r_done;

    logic [2:0] w_mux_s_nxt;
    logic       w_bit_valid_nxt;
    logic       w_bit_last_nxt;
    logic       w_done_nxt;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= 3'd0;
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state logic plus the next value of every registered output.
    // Outputs are derived from the next state so that they line up with
    // the state they describe once registered.
    always_comb begin
        w_state_nxt     = r_state;
        w_step_nxt      = r_step;
        w_hold_nxt      = r_hold;
        w_capture       = 1'b0;
        w_mux_s_nxt     = START_IDX;
        w_bit_valid_nxt = 1'b0;
        w_bit_last_nxt  = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RUN;
                    w_step_nxt  = 3'd0;
                    w_hold_nxt  = HOLD_LOAD;
                end
            end
            RUN: begin
                if (r_hold != 8'd0) begin
                    w_hold_nxt = r_hold - 8'd1;
                end else if (r_step != 3'd7) begin
                    w_step_nxt = r_step + 3'd1;
                    w_hold_nxt = HOLD_LOAD;
                end else begin
                    w_state_nxt = DONE;
                    w_step_nxt  = 3'd0;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_step_nxt  = 3'd0;
                w_hold_nxt  = 8'd0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = 3'd0;
                w_hold_nxt  = 8'd0;
            end
        endcase

        if (w_state_nxt == RUN) begin
            // 7 - step is the bitwise inverse for a 3-bit value.
            w_mux_s_nxt     = MSB_FIRST ? ~w_step_nxt : w_step_nxt;
            w_bit_valid_nxt = 1'b1;
            w_bit_last_nxt  = (w_step_nxt == 3'd7);
        end
        w_done_nxt = (w_state_nxt == DONE);
    end

    // Registered outputs; mux_i only changes on an accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mux_i     <= 8'd0;
            r_mux_s     <= START_IDX;
            r_bit_valid <= 1'b0;
            r_bit_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_mux_i <= in_data;
            end
            r_mux_s     <= w_mux_s_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_bit_last  <= w_bit_last_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign mux_i     = r_mux_i;
    assign mux_s     = r_mux_s;
    assign bit_valid = r_bit_valid;
    assign bit_last  = r_bit_last;
    assign done      = r_done;

endmodule

// File: tb/tb_mux8_sel_sequencer.sv
// tb_mux8_sel_sequencer
//
// Four sequencer instances with different hold/order settings share the
// clock, reset and data bus; each has its own in_valid. Frames are driven
// from a table of words with hand-computed serial bit patterns and frame
// lengths, and a few hand-written sequences cover back-pressure, mid-frame
// reset and the idle state.
//   instance 0 : HOLD_CYCLES=1,   LSB first
//   instance 1 : HOLD_CYCLES=3,   MSB first
//   instance 2 : HOLD_CYCLES=2,   LSB first
//   instance 3 : HOLD_CYCLES=256, LSB first

module tb_mux8_sel_sequencer;

    typedef struct {
        int         dut;
        logic [7:0] word;
        int         hold;
        bit         msb;
        logic [7:0] expBits;
        int         doneAt;
    } frameVec_t;

    logic       clk;
    logic       rstN;
    logic [7:0] inData;
    logic       inValid  [4];
    logic       inReady  [4];
    logic [7:0] muxI     [4];
    logic [2:0] muxS     [4];
    logic       bitValid [4];
    logic       bitLast  [4];
    logic       done     [4];

    int nCompared;
    int nMismatched;

    frameVec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sequencer per configuration under test.
    for (genvar g = 0; g < 4; g++) begin : gDut
        mux8_sel_sequencer #(
            .HOLD_CYCLES(g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 2 : 256),
            .MSB_FIRST  (g == 1)
        ) uDut (
            .clk      (clk),
            .rst_n    (rstN),
            .in_valid (inValid[g]),
            .in_ready (inReady[g]),
            .in_data  (inData),
            .mux_i    (muxI[g]),
            .mux_s    (muxS[g]),
            .bit_valid(bitValid[g]),
            .bit_last (bitLast[g]),
            .done     (done[g])
        );
    end

    // Single comparison point: counts every check and reports misses.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Idle/reset values of one instance; startIdx depends on its order.
    task automatic checkIdle(input int d, input logic [7:0] expMuxI, input logic [2:0] startIdx);
        checkOutput("idleMuxI", muxI[d], expMuxI);
        checkOutput("idleMuxS", muxS[d], startIdx);
        checkOutput("idleBitValid", bitValid[d], 0);
        checkOutput("idleBitLast", bitLast[d], 0);
        checkOutput("idleDone", done[d], 0);
        checkOutput("idleInReady", inReady[d], 1);
    endtask

    // Drive one word into an instance and check every cycle of its frame.
    task automatic applyStimulus(input frameVec_t v);
        int d;
        int k;
        int waitCnt;
        logic [2:0] expS;
        logic [2:0] startIdx;
        d = v.dut;
        waitCnt = 0;
        startIdx = v.msb ? 3'd7 : 3'd0;
        @(negedge clk);
        while (inReady[d] !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("readyBeforeFrame", inReady[d], 1);
        inData = v.word;
        inValid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid[d] = 1'b0;
        inData = ~v.word;
        for (int j = 1; j < v.doneAt; j++) begin
            if (j > 1) @(negedge clk);
            k = (j - 1) / v.hold;
            expS = v.msb ? 3'(7 - k) : 3'(k);
            checkOutput("runMuxS", muxS[d], expS);
            checkOutput("runBitValid", bitValid[d], 1);
            checkOutput("runBitLast", bitLast[d], (k == 7) ? 1 : 0);
            checkOutput("runDone", done[d], 0);
            checkOutput("runInReady", inReady[d], 0);
            checkOutput("runMuxI", muxI[d], v.word);
            checkOutput("serialBit", muxI[d][muxS[d]], v.expBits[k]);
        end
        @(negedge clk);
        checkOutput("donePulse", done[d], 1);
        checkOutput("doneBitValid", bitValid[d], 0);
        checkOutput("doneBitLast", bitLast[d], 0);
        checkOutput("doneMuxS", muxS[d], startIdx);
        checkOutput("doneInReady", inReady[d], 0);
        @(negedge clk);
        checkOutput("afterInReady", inReady[d], 1);
        checkOutput("afterDone", done[d], 0);
        checkOutput("afterMuxI", muxI[d], v.word);
    endtask

    initial begin
        int waitCnt;
        nCompared = 0;
        nMismatched = 0;
        inData = 8'h00;
        for (int i = 0; i < 4; i++) inValid[i] = 1'b0;

        // Serial pattern bit k is the bit seen at step k.
        vecs[0] = '{dut: 0, word: 8'hA5, hold: 1,   msb: 1'b0, expBits: 8'hA5, doneAt: 9};
        vecs[1] = '{dut: 0, word: 8'h3C, hold: 1,   msb: 1'b0, expBits: 8'h3C, doneAt: 9};
        vecs[2] = '{dut: 1, word: 8'h81, hold: 3,   msb: 1'b1, expBits: 8'h81, doneAt: 25};
        vecs[3] = '{dut: 1, word: 8'hC1, hold: 3,   msb: 1'b1, expBits: 8'h83, doneAt: 25};
        vecs[4] = '{dut: 2, word: 8'hC3, hold: 2,   msb: 1'b0, expBits: 8'hC3, doneAt: 17};
        vecs[5] = '{dut: 3, word: 8'h01, hold: 256, msb: 1'b0, expBits: 8'h01, doneAt: 2049};

        // Power-on reset.
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) checkIdle(i, 8'h00, (i == 1) ? 3'd7 : 3'd0);
        rstN = 1'b1;

        // Idle with in_valid low stays idle.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            inData = 8'(c * 37);
            checkOutput("idleHoldInReady", inReady[0], 1);
            checkOutput("idleHoldBitValid", bitValid[0], 0);
            checkOutput("idleHoldMuxS", muxS[0], 0);
            checkOutput("idleHoldDone", done[0], 0);
        end
        checkOutput("idleHoldMuxI", muxI[0], 8'h00);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Back-to-back pressure on instance 0: the second word waits for
        // the DONE cycle and in_data changes mid-frame are ignored.
        @(negedge clk);
        checkOutput("b2bReadyStart", inReady[0], 1);
        inData = 8'h0F;
        inValid[0] = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (j == 3) inData = 8'hFF;
            if (j == 9) inData = 8'hF0;
            if (j <= 9) checkOutput("b2bNotReady", inReady[0], 0);
            if (j == 5) checkOutput("b2bMuxIHeld", muxI[0], 8'h0F);
            if (j == 9) begin
                checkOutput("b2bMuxIAtDone", muxI[0], 8'h0F);
                checkOutput("b2bDone", done[0], 1);
            end
            if (j == 10) begin
                checkOutput("b2bReadyAgain", inReady[0], 1);
                checkOutput("b2bMuxIIdle", muxI[0], 8'h0F);
            end
            if (j == 11) begin
                checkOutput("b2bSecondWord", muxI[0], 8'hF0);
                checkOutput("b2bSecondValid", bitValid[0], 1);
                checkOutput("b2bSecondMuxS", muxS[0], 0);
                inValid[0] = 1'b0;
            end
        end
        waitCnt = 0;
        while (inReady[0] !== 1'b1 && waitCnt < 30) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("b2bFrameEnds", inReady[0], 1);

        // Reset in the middle of step 4 of an H=2 frame on instance 2.
        @(negedge clk);
        inData = 8'h6B;
        inValid[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid[2] = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("midStep4MuxS", muxS[2], 4);
        checkOutput("midStep4MuxI", muxI[2], 8'h6B);
        rstN = 1'b0;
        #1;
        checkIdle(2, 8'h00, 3'd0);
        checkIdle(0, 8'h00, 3'd0);
        checkIdle(1, 8'h00, 3'd7);
        @(negedge clk);
        rstN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("midNoDone", done[2], 0);
            checkOutput("midIdleReady", inReady[2], 1);
            checkOutput("midIdleValid", bitValid[2], 0);
        end
        applyStimulus('{dut: 2, word: 8'h5E, hold: 2, msb: 1'b0, expBits: 8'h5E, doneAt: 17});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mux8_sel_sequencer.md
# mux8_sel_sequencer

Parallel-to-serial front end for the 8:1 data-select mux. It accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the 3-bit select through all eight positions so the mux output carries one serial bit per step. It also flags which mux-output cycles are valid and signals when the frame is complete.

## Interface
- HOLD_CYCLES, 1: clock cycles each select value is held (legal 1..256).
- MSB_FIRST, 0: 0 = select order 0→7; 1 = select order 7→0.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word.
- in_data  input  8  word to serialise.
- mux_i  output  8  captured word, drives mux data inputs.
- mux_s  output  3  select, drives mux select inputs.
- bit_valid  output  1  mux output is a valid serial bit this cycle.
- bit_last  output  1  current step is the final (8th) step.
- done  output  1  one-cycle pulse after the frame ends.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Internal counters: 3-bit step counter and 8-bit hold counter (counts HOLD_CYCLES-1 down to 0).
- IDLE behaviour:
  - in_ready=1, mux_s=start index (0, or 7 if MSB_FIRST), bit_valid=0.
  - On in_valid&&in_ready: capture in_data into mux_i, load the hold counter, and move to RUN.
- RUN behaviour:
  - bit_valid=1, in_ready=0.
  - mux_s = step (MSB_FIRST=0) or 7-step (MSB_FIRST=1).
  - When the hold counter reaches 0: if step<7, increment step and reload the hold counter; if step==7, move to DONE.
  - bit_last=1 for every cycle of step 7.
- DONE behaviour:
  - done=1, bit_valid=0, in_ready=0, mux_s=start index.
  - Unconditionally moves to IDLE on the next cycle.
- mux_i is written only on an accepted handshake. It holds its value through DONE and IDLE until the next capture.
- in_valid and in_data are ignored outside IDLE. Changes to in_data mid-frame have no effect.
- No back-to-back acceptance: at least one DONE cycle separates frames.
- Reset values: state IDLE, mux_i=0, mux_s=start index, step=0, hold=0, bit_valid=0, bit_last=0, done=0, in_ready=1 (decoded from IDLE).
- Reset mid-frame: all outputs take their reset values immediately and asynchronously. The frame is abandoned and no done is issued.

## Timing
- Handshake accepted at edge T. Then:
  - From T+1, mux_i = the captured word, mux_s = first index, bit_valid=1.
  - Step k (0..7) occupies cycles T+1+k·H through T+(k+1)·H, where H=HOLD_CYCLES.
  - done is high during cycle T+8H+1.
  - in_ready returns to 1 at T+8H+2.
- Frame period: 8H+2 cycles per word at full upstream throughput.
- All outputs are registered except in_ready, which is decoded from state with no combinational path from inputs.
- H=1: mux_s changes every cycle and there is no idle hold. H=256: the hold counter loads 255.

## Test plan
- Reset/idle, H=1, MSB_FIRST=0: assert rst_n=0 mid-sim → mux_i=0, mux_s=0, bit_valid=0, done=0, in_ready=1. Hold in_valid=0 for 20 cycles → outputs stay at idle values.
- Basic frame, H=1, MSB_FIRST=0: in_data=8'hA5 accepted at T.
  - mux_s sequence 0..7 over T+1..T+8, and mux output reads 1,0,1,0,0,1,0,1.
  - bit_last only at T+8, done at T+9, in_ready=1 at T+10.
- Hold and order, H=3, MSB_FIRST=1: in_data=8'h81 → mux_s 7,7,7,6,6,6,…,0,0,0 over 24 cycles, done at T+25.
- Back-to-back pressure: in_valid held high with 8'h0F then 8'hF0.
  - The second word is accepted only at T+10 (H=1).
  - in_data changed to 8'hFF during the first frame → mux_i stays 8'h0F.
- Reset mid-frame: drop rst_n at step 4 of an H=2 frame → immediate reset values with no done pulse. After release, a new word is accepted normally.
- Boundary H=256: one frame of 8'h01 → each mux_s value held 256 cycles, done at T+2049.
